// File: rtl/dds_pkg.sv
// Shared DDS definitions: quadrant codes, midscale and quarter-wave ROM contents.
// The ROM contents are computed at elaboration time.
package dds_pkg;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    function automatic int midscale(input int w);
        return 1 << (w - 1);
    endfunction

    // Half-LSB phase offset keeps the mirrored wave symmetric about midscale
    function automatic int rom_entry(input int k, input int addr_w, input int out_w);
        real amp;
        real ang;
        amp = real'((1 << (out_w - 1)) - 1);
        ang = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(1 << addr_w);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/dds_quarter_rom.sv
// Registered-read quarter-wave sine ROM; a second read port is added when DDS_COS_EN is defined.
// Build option: DDS_COS_EN.
module dds_quarter_rom
    import dds_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] data_a
`ifdef DDS_COS_EN
    ,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_b
`endif
);

    logic [DATA_W-1:0] rom [2**ADDR_W];

    for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_rom
        localparam int V = rom_entry(k, ADDR_W, DATA_W + 1);
        assign rom[k] = DATA_W'(V);
    end

    always_ff @(posedge clk) begin
        data_a <= rom[addr_a];
    end

`ifdef DDS_COS_EN
    always_ff @(posedge clk) begin
        data_b <= rom[addr_b];
    end
`endif

endmodule

// File: rtl/dds_sine_gen.sv
// Pipelined DDS sine generator: accumulator, offset, quadrant fold, ROM, sign restore.
// Build option: DDS_COS_EN adds cos_out (quarter-turn lead), same latency and valid.
module dds_sine_gen
    import dds_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 6,
    parameter int OUT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ftw_load,
    input  logic [ACC_W-1:0]  ftw_i,
    input  logic [ADDR_W+1:0] pofs_i,
    input  logic              sync_clr,
    output logic              out_valid,
    output logic [OUT_W-1:0]  sin_out
`ifdef DDS_COS_EN
    ,
    output logic [OUT_W-1:0]  cos_out
`endif
);

    localparam int PHASE_W = ADDR_W + 2;
    localparam int DATA_W  = OUT_W - 1;
    localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));
    localparam logic [PHASE_W-1:0] QTR = {2'b01, {ADDR_W{1'b0}}};

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   ftw;
    logic [PHASE_W-1:0] ph;
    logic [PHASE_W-1:0] ph_s1;
    logic               v1;
    logic               v2;
    logic               neg_s2;
    logic [DATA_W-1:0]  rom_s;

    function automatic logic [ADDR_W-1:0] fold(input logic [PHASE_W-1:0] p);
        logic [ADDR_W-1:0] r;
        r = p[ADDR_W-1:0];
        unique case (p[PHASE_W-1 -: 2])
            Q0, Q2: r = p[ADDR_W-1:0];
            Q1, Q3: r = ~p[ADDR_W-1:0];
        endcase
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] unfold(input logic neg, input logic [DATA_W-1:0] d);
        return neg ? (MID - OUT_W'(1) - {1'b0, d}) : (MID + {1'b0, d});
    endfunction

    // Old ftw feeds the accumulator when a load coincides with en
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            ftw <= '0;
        end else begin
            if (ftw_load)
                ftw <= ftw_i;
            if (sync_clr)
                acc <= '0;
            else if (en)
                acc <= acc + ftw;
        end
    end

    assign ph = acc[ACC_W-1 -: PHASE_W] + pofs_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_s1  <= '0;
            v1     <= 1'b0;
            neg_s2 <= 1'b0;
            v2     <= 1'b0;
        end else begin
            ph_s1  <= ph;
            v1     <= en;
            neg_s2 <= ph_s1[PHASE_W-1];
            v2     <= v1;
        end
    end

`ifdef DDS_COS_EN
    logic [PHASE_W-1:0] phc_s1;
    logic               negc_s2;
    logic [DATA_W-1:0]  romc_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            phc_s1  <= '0;
            negc_s2 <= 1'b0;
        end else begin
            phc_s1  <= ph + QTR;
            negc_s2 <= phc_s1[PHASE_W-1];
        end
    end

    dds_quarter_rom #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_rom (
        .clk   (clk),
        .addr_a(fold(ph_s1)),
        .data_a(rom_s),
        .addr_b(fold(phc_s1)),
        .data_b(romc_s)
    );

    always_ff @(posedge clk) begin
        if (rst)
            cos_out <= MID;
        else if (v2)
            cos_out <= unfold(negc_s2, romc_s);
    end
`else
    dds_quarter_rom #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_rom (
        .clk   (clk),
        .addr_a(fold(ph_s1)),
        .data_a(rom_s)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sin_out   <= MID;
        end else begin
            out_valid <= v2;
            if (v2)
                sin_out <= unfold(neg_s2, rom_s);
        end
    end

endmodule

// File: tb/tb_dds_sine_gen.sv
// Scoreboard bench for dds_sine_gen: driver pushes expected samples, monitor pops on out_valid.
// Works with or without DDS_COS_EN.
module tb_dds_sine_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ftw_load;
    logic [23:0] ftw_i;
    logic [7:0]  pofs_i;
    logic        sync_clr;
    logic        out_valid;
    logic [9:0]  sin_out;
`ifdef DDS_COS_EN
    logic [9:0]  cos_out;
`endif

    always #5 clk = ~clk;

    dds_sine_gen #(
        .ACC_W (24),
        .ADDR_W(6),
        .OUT_W (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ftw_load (ftw_load),
        .ftw_i    (ftw_i),
        .pofs_i   (pofs_i),
        .sync_clr (sync_clr),
        .out_valid(out_valid),
        .sin_out  (sin_out)
`ifdef DDS_COS_EN
        ,
        .cos_out  (cos_out)
`endif
    );

    typedef struct {
        int due;
        int s;
        int c;
    } exp_t;

    exp_t        q[$];
    int          tests;
    int          fails;
    int          cyc;
    logic [23:0] acc_m;
    logic [23:0] ftw_m;

    function automatic int ref_sin(input int ph);
        int p, qd, a, addr, r;
        p    = ph & 255;
        qd   = p >> 6;
        a    = p & 63;
        addr = (qd & 1) != 0 ? 63 - a : a;
        r    = $rtoi(511.0 * $sin(3.14159265358979 / 2.0 * (real'(addr) + 0.5) / 64.0) + 0.5);
        return (qd & 2) != 0 ? 511 - r : 512 + r;
    endfunction

    function automatic int expect_at(input int ph);
        case (ph & 255)
            0:       return 518;
            64:      return 1023;
            128:     return 505;
            192:     return 0;
            default: return ref_sin(ph);
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("latency", cyc, e.due);
                chk("sin_out", int'(sin_out), e.s);
`ifdef DDS_COS_EN
                chk("cos_out", int'(cos_out), e.c);
`endif
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            chk("missing_valid", 0, 1);
            void'(q.pop_front());
        end
    end

    task automatic step(input logic e, input logic ld, input logic [23:0] f,
                        input logic [7:0] po, input logic clr);
        exp_t        x;
        logic [7:0]  ph;
        logic [23:0] old;
        @(negedge clk);
        en       = e;
        ftw_load = ld;
        ftw_i    = f;
        pofs_i   = po;
        sync_clr = clr;
        if (e) begin
            ph    = acc_m[23:16] + po;
            x.due = cyc + 3;
            x.s   = expect_at(int'(ph));
            x.c   = expect_at(int'(ph) + 64);
            q.push_back(x);
        end
        old = ftw_m;
        if (ld)
            ftw_m = f;
        if (clr)
            acc_m = '0;
        else if (e)
            acc_m = acc_m + old;
    endtask

    task automatic after_edge_acc(input string nm, input int req);
        @(posedge clk);
        #2;
        chk(nm, int'(dut.acc), req);
    endtask

    task automatic do_reset(input int n, input logic e);
        @(negedge clk);
        rst      = 1'b1;
        en       = e;
        ftw_load = 1'b0;
        sync_clr = 1'b0;
        q.delete();
        acc_m = '0;
        ftw_m = '0;
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sin", int'(sin_out), 512);
        chk("rst_acc", int'(dut.acc), 0);
        repeat (n - 1) @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ftw_load = 1'b0; ftw_i = '0;
        pofs_i = '0; sync_clr = 1'b0;
        tests = 0; fails = 0; cyc = 0; acc_m = '0; ftw_m = '0;

        repeat (2) @(negedge clk);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_sin", int'(sin_out), 512);
        chk("reset_acc", int'(dut.acc), 0);
`ifdef DDS_COS_EN
        chk("reset_cos", int'(cos_out), 512);
`endif
        rst = 1'b0;

        // Full-period sweep at one phase step per sample
        step(1'b0, 1'b1, 24'h010000, 8'd0, 1'b0);
        repeat (260) step(1'b1, 1'b0, '0, 8'd0, 1'b0);

        // Phase sync while running
        step(1'b1, 1'b0, '0, 8'd0, 1'b1);
        after_edge_acc("sync_clr_acc", 0);
        repeat (10) step(1'b1, 1'b0, '0, 8'd0, 1'b0);

        // Frozen phase with offset, then cosine lead
        step(1'b0, 1'b1, 24'h0, 8'd0, 1'b1);
        repeat (8) step(1'b1, 1'b0, '0, 8'd64, 1'b0);
        repeat (4) step(1'b1, 1'b0, '0, 8'd0, 1'b0);

        // Accumulator wrap and load-with-accumulate ordering
        step(1'b0, 1'b1, 24'hFFFF00, 8'd0, 1'b1);
        step(1'b1, 1'b0, '0, 8'd0, 1'b0);
        step(1'b0, 1'b1, 24'h000200, 8'd0, 1'b0);
        step(1'b1, 1'b0, '0, 8'd0, 1'b0);
        after_edge_acc("wrap_acc", 24'h000100);
        step(1'b1, 1'b1, 24'h010000, 8'd0, 1'b0);
        after_edge_acc("load_old_ftw", 24'h000300);
        step(1'b1, 1'b0, '0, 8'd0, 1'b0);
        after_edge_acc("load_new_ftw", 24'h010300);
        repeat (3) step(1'b1, 1'b0, '0, 8'd5, 1'b0);

        // Reset in the middle of a running sweep
        step(1'b0, 1'b1, 24'h010000, 8'd0, 1'b0);
        repeat (20) step(1'b1, 1'b0, '0, 8'd0, 1'b0);
        do_reset(2, 1'b1);
        repeat (5) step(1'b1, 1'b0, '0, 8'd0, 1'b0);

        step(1'b0, 1'b0, '0, 8'd0, 1'b0);
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() != 0)
            chk("drain", q.size(), 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
